// File: rtl/dsp_mac_ctrl_if.sv
// Operand stream, slice drive/return and result channels of the MAC sequencer.
// master = sequencer side, slave = producer/consumer/slice side.
interface dsp_mac_ctrl_if #(
    parameter int CNT_W = 8
);
    logic                    op_valid;
    logic                    op_ready;
    logic signed [17:0]      op_a;
    logic signed [17:0]      op_b;
    logic                    op_last;

    logic signed [17:0]      DSP_A;
    logic signed [17:0]      DSP_B;
    logic        [7:0]       DSP_OPMODE;
    logic signed [47:0]      DSP_P;

    logic                    res_valid;
    logic                    res_ready;
    logic signed [47:0]      res_data;
    logic        [CNT_W-1:0] res_count;
    logic                    res_sat;

    modport master (
        input  op_valid, op_a, op_b, op_last, DSP_P, res_ready,
        output op_ready, DSP_A, DSP_B, DSP_OPMODE, res_valid, res_data, res_count, res_sat
    );

    modport slave (
        output op_valid, op_a, op_b, op_last, DSP_P, res_ready,
        input  op_ready, DSP_A, DSP_B, DSP_OPMODE, res_valid, res_data, res_count, res_sat
    );
endinterface

// File: rtl/dsp_mac_ctrl.sv
// MAC sequencer driving a DSP48A1 slice; result valid LATENCY+1 edges after the last beat.
// op_ready drops in DRAIN/RESULT, so operand beats stall until the result is taken.
module dsp_mac_ctrl #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    dsp_mac_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACC   = 8'h09;
    localparam logic [7:0] OP_HOLD  = 8'h08;
    localparam logic [7:0] OP_CLR   = 8'h00;

    state_t             state, state_nxt;
    logic               accept;
    logic [2:0]         drain_cnt;
    logic [CNT_W-1:0]   beat_cnt;
    logic               beat_sat;

    logic signed [17:0] dsp_a_q, dsp_b_q, dsp_a_nxt, dsp_b_nxt;
    logic [7:0]         dsp_op_q, dsp_op_nxt;

    logic               res_valid_q;
    logic signed [47:0] res_data_q;
    logic [CNT_W-1:0]   res_count_q;
    logic               res_sat_q;

    assign bus.op_ready   = !RST && (state == IDLE || state == ACCUM);
    assign accept         = bus.op_valid && bus.op_ready;

    assign bus.DSP_A      = dsp_a_q;
    assign bus.DSP_B      = dsp_b_q;
    assign bus.DSP_OPMODE = dsp_op_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_count  = res_count_q;
    assign bus.res_sat    = res_sat_q;

    always_comb begin
        state_nxt  = state;
        dsp_a_nxt  = '0;
        dsp_b_nxt  = '0;
        dsp_op_nxt = (state == IDLE) ? OP_CLR : OP_HOLD;

        if (accept) begin
            dsp_a_nxt  = bus.op_a;
            dsp_b_nxt  = bus.op_b;
            dsp_op_nxt = (state == IDLE) ? OP_FIRST : OP_ACC;
        end

        case (state)
            IDLE:    if (accept) state_nxt = bus.op_last ? DRAIN : ACCUM;
            ACCUM:   if (accept && bus.op_last) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 3'd0) state_nxt = RESULT;
            RESULT:  if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            dsp_op_q    <= OP_CLR;
            drain_cnt   <= '0;
            beat_cnt    <= '0;
            beat_sat    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_count_q <= '0;
            res_sat_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            dsp_a_q  <= dsp_a_nxt;
            dsp_b_q  <= dsp_b_nxt;
            dsp_op_q <= dsp_op_nxt;

            // Counts down once per edge in DRAIN; capture fires on the edge it reads zero.
            if (accept && bus.op_last) begin
                drain_cnt <= 3'(LATENCY);
            end else if (state == DRAIN && drain_cnt != 3'd0) begin
                drain_cnt <= drain_cnt - 3'd1;
            end

            if (accept) begin
                if (state == IDLE) begin
                    beat_cnt <= CNT_W'(1);
                    beat_sat <= 1'b0;
                end else if (&beat_cnt) begin
                    beat_sat <= 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end

            if (state == DRAIN && drain_cnt == 3'd0) begin
                res_valid_q <= 1'b1;
                res_data_q  <= bus.DSP_P;
                res_count_q <= beat_cnt;
                res_sat_q   <= beat_sat;
            end else if (state == RESULT && bus.res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/dsp_mac_ctrl.md
# dsp_mac_ctrl

Multiply-accumulate sequencer that drives the DSP48A1 slice model (`dsp`) from the initiator side. It accepts a stream of signed 18-bit operand pairs over a valid/ready handshake and issues them to the slice's A/B/OPMODE inputs. It holds the slice accumulator across input bubbles, waits out the slice's pipeline latency after the last beat, then returns the 48-bit dot product on a valid/ready result port. It replaces hand-written OPMODE stimulus wherever the slice is used as a MAC engine.

## Interface
- LATENCY, 1, register stages from the slice's A/B/OPMODE inputs to P; legal range 1..4; must match the attached slice configuration, which requires PREG=1.
- CNT_W, 8, width of the beat counter.

- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- op_valid  in  1  operand beat valid.
- op_ready  out  1  controller can accept a beat.
- op_a  in  18  signed multiplicand.
- op_b  in  18  signed multiplier.
- op_last  in  1  marks the final beat of a job.
- DSP_A  out  18  to slice A.
- DSP_B  out  18  to slice B.
- DSP_OPMODE  out  8  to slice OPMODE.
- DSP_P  in  48  from slice P.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  48  signed accumulated sum.
- res_count  out  CNT_W  beats in the job, saturating at all-ones.
- res_sat  out  1  beat count saturated.

## Operation
- States are IDLE, ACCUM, DRAIN and RESULT. RST forces IDLE from any state.
- OPMODE encodings use X=[1:0], Z=[3:2], and bits [7:4]=0:
  - FIRST = 8'h01 (P <= M).
  - ACC = 8'h09 (P <= P + M).
  - HOLD = 8'h08 (P <= P + 0).
  - CLR = 8'h00 (P <= 0).
- A beat is accepted on an edge where op_valid && op_ready.
- op_ready is 1 in IDLE and ACCUM, and 0 in DRAIN and RESULT.
- DSP_A, DSP_B and DSP_OPMODE are registered. On an accepting edge they load op_a, op_b, and FIRST (if the state was IDLE) or ACC (if ACCUM). On a non-accepting edge they load A=0, B=0 and HOLD in ACCUM/DRAIN/RESULT, or CLR in IDLE.
- Transitions:
  - IDLE -> ACCUM on an accepted beat with op_last=0.
  - IDLE or ACCUM -> DRAIN on an accepted beat with op_last=1. A single-beat job goes straight to DRAIN.
  - Entering DRAIN loads drain counter = LATENCY.
  - DRAIN decrements the counter on each edge. On the edge where the counter is 0, the controller captures DSP_P into res_data, sets res_valid and moves to RESULT.
  - RESULT -> IDLE on the edge where res_ready=1. res_valid drops on that edge.
- Beat counter:
  - Set to 1 on a FIRST beat and incremented on each ACC beat.
  - On overflow it stays at all-ones and sets res_sat.
  - Both values are copied to res_count and res_sat at capture.
- res_data, res_count and res_sat stay stable while res_valid=1.
- Arithmetic is two's complement. The 36-bit product is sign-extended to 48 bits by the slice, and sum wrap-around beyond 48 bits is not flagged.
- Reset values:
  - op_ready=0 while RST is high; it is 1 on the first cycle after.
  - DSP_A=0, DSP_B=0, DSP_OPMODE=CLR.
  - res_valid=0, res_data=0, res_count=0, res_sat=0.
  - Counters are 0.
- Reset mid-job abandons the job. The CLR opmode zeroes the slice accumulator before the next job's FIRST beat.

## Timing
- A beat accepted at edge e is presented to the slice during cycle e..e+1, and its contribution is visible on DSP_P after edge e+LATENCY.
- Result latency: last beat accepted at edge e gives res_valid=1 after edge e+LATENCY+1.
- Back-to-back jobs: the minimum gap from the result handshake to the next FIRST beat is 0 cycles, because IDLE accepts immediately.
- Input bubbles in ACCUM issue HOLD and do not alter the sum.
- Throughput is one beat per cycle while in ACCUM.
- op_valid asserted in DRAIN/RESULT is ignored and must stay pending; no beat is lost because op_ready=0.

## Test plan
- Three-beat job (5,6), (10,7), (110,78) with op_last on the third beat, LATENCY=1, slice with PREG=1 and other registers 0 → res_data=8680, res_count=3, res_valid 2 edges after the last accept.
- Single beat (-3, 7) with op_last=1 → res_data=48'hFFFF_FFFF_FFEB, res_count=1.
- Same three-beat job with op_valid deasserted 2 cycles between each beat → res_data=8680; DSP_OPMODE=8'h08 during the gaps.
- res_ready held low 5 cycles after res_valid → op_ready=0 and res_data constant throughout; res_valid drops one edge after res_ready rises.
- Two back-to-back jobs: (4,4) then (2,3) → results 16 then 6; the second result must not include the first.
- RST pulsed for one cycle after two beats of a job, then job (1,1) → all outputs at reset values during RST; next result=1, res_count=1.
